// File: rtl/nmt_pkg.sv
// Shared definitions for the near-memory-thread core pipeline:
// RV32 opcode/funct encodings, the NOP word and the execute-stage FSM states.
package nmt_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_MUL  = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } ex_state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier producing the low XLEN bits of a*b.
// One step per clock; done is asserted during the final step and p is valid then.
module mul_seq #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] p
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic [XLEN-1:0] w_acc_nxt;

    // p exposes the post-step accumulator so the caller can register the
    // product on the same edge that performs the last step.
    assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
    assign busy      = r_busy;
    assign done      = r_busy && (r_cnt == LAST);
    assign p         = w_acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            if (done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: inline single-cycle ALU / address generation plus an
// iterative MUL; emits a registered ALU/IR/reg2/cmd_type bundle every clock.
module ex_stage
    import nmt_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      cmd_type_i,
    output logic [XLEN-1:0] ALU,
    output logic [31:0]     IR,
    output logic [XLEN-1:0] reg2_o,
    output logic [1:0]      cmd_type
);
    ex_state_t       r_state;
    ex_state_t       w_state_nxt;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_reg2;
    logic [1:0]      r_cmd;
    logic [31:0]     r_mul_ir;
    logic [XLEN-1:0] r_mul_reg2;
    logic [1:0]      r_mul_cmd;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_shamt;
    logic            w_alt;
    logic            w_is_mul;
    logic [XLEN-1:0] w_alu;
    logic            w_accept;
    logic            w_mul_start;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mul_p;

    assign w_opcode = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];
    assign w_op_b   = (w_opcode == OP_R) ? reg2 : imm;
    assign w_shamt  = w_op_b[4:0];
    assign w_is_mul = (w_opcode == OP_R) && (w_f7 == F7_MULDIV) && (w_f3 == F3_MUL);

    assign in_ready    = (r_state == IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && w_is_mul;

    // Register ops use funct7[5] for SUB/SRA; immediate ops only for SRAI (imm[10]).
    always_comb begin
        w_alt = 1'b0;
        if (w_opcode == OP_R)
            w_alt = w_f7[5];
        else if (w_opcode == OP_I && w_f3 == F3_SR)
            w_alt = imm[10];
    end

    always_comb begin
        w_alu = '0;
        if ((w_opcode == OP_R && (w_f7 == F7_BASE || w_f7 == F7_ALT)) || w_opcode == OP_I) begin
            case (w_f3)
                F3_ADD:  w_alu = (w_alt && w_opcode == OP_R) ? reg1 - w_op_b : reg1 + w_op_b;
                F3_SLL:  w_alu = reg1 << w_shamt;
                F3_SLT:  w_alu = XLEN'($signed(reg1) < $signed(w_op_b));
                F3_SLTU: w_alu = XLEN'(reg1 < w_op_b);
                F3_XOR:  w_alu = reg1 ^ w_op_b;
                F3_SR:   w_alu = w_alt ? XLEN'($signed(reg1) >>> w_shamt) : reg1 >> w_shamt;
                F3_OR:   w_alu = reg1 | w_op_b;
                F3_AND:  w_alu = reg1 & w_op_b;
                default: w_alu = '0;
            endcase
        end else if (w_opcode == OP_LOAD || w_opcode == OP_STORE) begin
            w_alu = reg1 + imm;
        end else if (w_opcode == OP_LUI) begin
            w_alu = imm;
        end
    end

    mul_seq #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_mul_start),
        .a     (reg1),
        .b     (reg2),
        .busy  (w_mul_busy),
        .done  (w_mul_done),
        .p     (w_mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_nxt = MUL;
            MUL:     if (w_mul_done && w_mul_busy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Any edge without a finished result drives a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu      <= '0;
            r_ir       <= NOP_INSTR;
            r_reg2     <= '0;
            r_cmd      <= 2'b00;
            r_mul_ir   <= NOP_INSTR;
            r_mul_reg2 <= '0;
            r_mul_cmd  <= 2'b00;
        end else begin
            r_alu  <= '0;
            r_ir   <= NOP_INSTR;
            r_reg2 <= '0;
            r_cmd  <= 2'b00;
            if (w_mul_start) begin
                r_mul_ir   <= instr_i;
                r_mul_reg2 <= reg2;
                r_mul_cmd  <= cmd_type_i;
            end else if (w_accept) begin
                r_alu  <= w_alu;
                r_ir   <= instr_i;
                r_reg2 <= reg2;
                r_cmd  <= cmd_type_i;
            end else if (r_state == MUL && w_mul_done) begin
                r_alu  <= w_mul_p;
                r_ir   <= r_mul_ir;
                r_reg2 <= r_mul_reg2;
                r_cmd  <= r_mul_cmd;
            end
        end
    end

    assign ALU      = r_alu;
    assign IR       = r_ir;
    assign reg2_o   = r_reg2;
    assign cmd_type = r_cmd;

endmodule
